// File: rtl/decode_ctrl_pkg.sv
// Shared constants for the decode stage: RV32 opcodes, immediate format codes,
// the canonical NOP and the entry-buffer state encoding.
package decode_ctrl_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] IMM_SEL_I   = 3'd0;
    localparam logic [2:0] IMM_SEL_S   = 3'd1;
    localparam logic [2:0] IMM_SEL_B   = 3'd2;
    localparam logic [2:0] IMM_SEL_U   = 3'd3;
    localparam logic [2:0] IMM_SEL_J   = 3'd4;
    localparam logic [2:0] IMM_SEL_CSR = 3'd5;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/decode_ctrl_imm_gen.sv
// Immediate generator: expands the instruction fields into an XLEN immediate
// for the selected format. The zimm format exists only when DECODE_CSR_EN is defined.
module decode_ctrl_imm_gen
    import decode_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:7] i_fields,
    input  logic [2:0]      i_imm_sel,
    output logic [XLEN-1:0] o_imm
);

    always_comb begin
        o_imm = '0;
        case (i_imm_sel)
            IMM_SEL_I: o_imm = XLEN'($signed(i_fields[31:20]));
            IMM_SEL_S: o_imm = XLEN'($signed({i_fields[31:25], i_fields[11:7]}));
            IMM_SEL_B: o_imm = XLEN'($signed({i_fields[31], i_fields[7], i_fields[30:25],
                                               i_fields[11:8], 1'b0}));
            IMM_SEL_U: o_imm = XLEN'($signed({i_fields[31:12], 12'b0}));
            IMM_SEL_J: o_imm = XLEN'($signed({i_fields[31], i_fields[19:12], i_fields[20],
                                               i_fields[30:21], 1'b0}));
`ifdef DECODE_CSR_EN
            IMM_SEL_CSR: o_imm = XLEN'(i_fields[19:15]);
`endif
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage controller: classifies fetched instructions, captures the immediate,
// and hands a registered bundle to execute through a main + skid entry pair.
// Optional CSR decode is enabled by defining DECODE_CSR_EN.
module decode_ctrl
    import decode_ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_sel,
    output logic            out_illegal
);

    state_t          r_state;
    state_t          w_state_next;

    logic [XLEN-1:0] r_out_inst, r_out_pc, r_out_imm;
    logic [2:0]      r_out_sel;
    logic            r_out_ill;

    logic [XLEN-1:0] r_skid_inst, r_skid_pc, r_skid_imm;
    logic [2:0]      r_skid_sel;
    logic            r_skid_ill;

    logic [2:0]      w_dec_sel;
    logic            w_dec_ill;
    logic [XLEN-1:0] w_dec_imm;

    logic            w_in_fire, w_out_fire;
    logic            w_load_main_in, w_load_main_skid, w_load_skid;

    // Classification happens on the input side so each entry carries its decode.
    always_comb begin
        w_dec_sel = IMM_SEL_I;
        w_dec_ill = 1'b0;
        case (in_inst[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_OP: w_dec_sel = IMM_SEL_I;
            OPC_STORE:                              w_dec_sel = IMM_SEL_S;
            OPC_BRANCH:                             w_dec_sel = IMM_SEL_B;
            OPC_LUI, OPC_AUIPC:                     w_dec_sel = IMM_SEL_U;
            OPC_JAL:                                w_dec_sel = IMM_SEL_J;
`ifdef DECODE_CSR_EN
            OPC_SYSTEM: w_dec_sel = in_inst[14] ? IMM_SEL_CSR : IMM_SEL_I;
`endif
            default:                                w_dec_ill = 1'b1;
        endcase
    end

    decode_ctrl_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .i_fields  (in_inst[XLEN-1:7]),
        .i_imm_sel (w_dec_sel),
        .o_imm     (w_dec_imm)
    );

    assign in_ready   = ~rst & (r_state != ST_FULL);
    assign out_valid  = (r_state != ST_EMPTY);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_load_main_in = 1'b1;
                        w_state_next   = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main_in = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_next = ST_EMPTY;
                    end else if (w_in_fire) begin
                        w_load_skid  = 1'b1;
                        w_state_next = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_load_main_skid = 1'b1;
                        w_state_next     = ST_BUSY;
                    end
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_inst  <= XLEN'(NOP_INST);
            r_out_pc    <= RESET_PC;
            r_out_imm   <= '0;
            r_out_sel   <= IMM_SEL_I;
            r_out_ill   <= 1'b0;
            r_skid_inst <= XLEN'(NOP_INST);
            r_skid_pc   <= RESET_PC;
            r_skid_imm  <= '0;
            r_skid_sel  <= IMM_SEL_I;
            r_skid_ill  <= 1'b0;
        end else begin
            if (w_load_main_in) begin
                r_out_inst <= in_inst;
                r_out_pc   <= in_pc;
                r_out_imm  <= w_dec_imm;
                r_out_sel  <= w_dec_sel;
                r_out_ill  <= w_dec_ill;
            end else if (w_load_main_skid) begin
                r_out_inst <= r_skid_inst;
                r_out_pc   <= r_skid_pc;
                r_out_imm  <= r_skid_imm;
                r_out_sel  <= r_skid_sel;
                r_out_ill  <= r_skid_ill;
            end
            if (w_load_skid) begin
                r_skid_inst <= in_inst;
                r_skid_pc   <= in_pc;
                r_skid_imm  <= w_dec_imm;
                r_skid_sel  <= w_dec_sel;
                r_skid_ill  <= w_dec_ill;
            end
        end
    end

    assign out_inst    = r_out_inst;
    assign out_pc      = r_out_pc;
    assign out_imm     = r_out_imm;
    assign out_imm_sel = r_out_sel;
    assign out_illegal = r_out_ill;

endmodule

// File: tb/tb_decode_ctrl.sv
// Testbench for decode_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based model of the two-deep decode buffer.
module tb_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [2:0]  out_imm_sel;
    logic        out_illegal;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  sel;
        logic        ill;
    } entry_t;

    entry_t q[$];
    int     checks   = 0;
    int     failures = 0;

    always #5 clk = ~clk;

    decode_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_imm     (out_imm),
        .out_imm_sel (out_imm_sel),
        .out_illegal (out_illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference decode, written from the instruction-format tables.
    function automatic entry_t model(input logic [31:0] inst, input logic [31:0] pc);
        entry_t e;
        int     v;
        e.inst = inst;
        e.pc   = pc;
        e.sel  = 3'd0;
        e.ill  = 1'b0;
        case (inst[6:0])
            7'h13, 7'h03, 7'h67, 7'h33: e.sel = 3'd0;
            7'h23: e.sel = 3'd1;
            7'h63: e.sel = 3'd2;
            7'h37, 7'h17: e.sel = 3'd3;
            7'h6F: e.sel = 3'd4;
`ifdef DECODE_CSR_EN
            7'h73: e.sel = inst[14] ? 3'd5 : 3'd0;
`endif
            default: e.ill = 1'b1;
        endcase
        case (e.sel)
            3'd0: v = int'(inst[31:20]) - (inst[31] ? 4096 : 0);
            3'd1: v = int'({inst[31:25], inst[11:7]}) - (inst[31] ? 4096 : 0);
            3'd2: v = int'({inst[7], inst[30:25], inst[11:8]}) * 2 - (inst[31] ? 4096 : 0);
            3'd3: v = int'(inst[31:12]) * 4096;
            3'd4: v = int'({inst[19:12], inst[20], inst[30:21]}) * 2 - (inst[31] ? 1048576 : 0);
            default: v = int'(inst[19:15]);
        endcase
        e.imm = v;
        return e;
    endfunction

    // One cycle: drive at negedge, check outputs against the model, update model.
    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        logic in_fire, out_fire;
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        check("in_ready", in_ready, q.size() < 2);
        check("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            check("out_inst", out_inst, q[0].inst);
            check("out_pc", out_pc, q[0].pc);
            check("out_imm", out_imm, q[0].imm);
            check("out_imm_sel", out_imm_sel, q[0].sel);
            check("out_illegal", out_illegal, q[0].ill);
        end
        in_fire  = v && (q.size() < 2);
        out_fire = ordy && (q.size() > 0);
        if (out_fire) void'(q.pop_front());
        if (fl) q.delete();
        else if (in_fire) q.push_back(model(inst, pc));
        $display("cyc t=%0t v=%0b inst=%08h pc=%08h ordy=%0b fl=%0b in_fire=%0b out_fire=%0b depth=%0d",
                 $time, v, inst, pc, ordy, fl, in_fire, out_fire, q.size());
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        flush     = 1'b0;
        in_inst   = 32'h0050_0093;
        in_pc     = 32'h0;
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_inst", out_inst, 32'h0000_0013);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_imm", out_imm, 32'h0);
        check("rst_out_sel", out_imm_sel, 3'd0);
        check("rst_out_ill", out_illegal, 1'b0);
        q.delete();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
    endtask

    logic [6:0] opc_tbl [12] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                                 7'h17, 7'h6F, 7'h73, 7'h33, 7'h00, 7'h7F};

    initial begin
        logic [31:0] r, inst, pc;
        @(negedge clk);
        do_reset();

        // addi x1,x0,5 with 1-cycle latency
        step(1, 32'h0050_0093, 32'h100, 1, 0);
        check("addi_valid", out_valid, 1'b1);
        check("addi_imm", out_imm, 32'd5);
        check("addi_sel", out_imm_sel, 3'd0);
        check("addi_ill", out_illegal, 1'b0);
        step(0, 32'h0, 32'h0, 1, 0);

        // back-pressure: beq then jal, then drain in order
        step(1, 32'hFE00_0EE3, 32'h200, 0, 0);
        step(1, 32'h0000_006F, 32'h204, 0, 0);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_beq_imm", out_imm, 32'hFFFF_FFFC);
        check("bp_beq_sel", out_imm_sel, 3'd2);
        step(0, 32'h0, 32'h0, 1, 0);
        check("bp_jal_imm", out_imm, 32'h0);
        check("bp_jal_sel", out_imm_sel, 3'd4);
        step(0, 32'h0, 32'h0, 1, 0);

        // full-rate streaming never fills the skid
        for (int i = 0; i < 8; i++) step(1, 32'h0000_0013 | (i << 7), 32'h300 + i * 4, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        // flush while FULL with an input offered in the same cycle
        step(1, 32'h1234_5037, 32'h400, 0, 0);
        check("lui_imm", out_imm, 32'h1234_5000);
        check("lui_sel", out_imm_sel, 3'd3);
        step(1, 32'h0000_0000, 32'h404, 0, 0);
        step(1, 32'h0002_D073, 32'h408, 0, 1);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        step(0, 32'h0, 32'h0, 1, 0);

        // illegal opcode and CSR immediate
        step(1, 32'h0000_0000, 32'h500, 0, 0);
        check("illegal_opc0", out_illegal, 1'b1);
        step(1, 32'h0002_D073, 32'h504, 1, 0);
`ifdef DECODE_CSR_EN
        check("csr_sel", out_imm_sel, 3'd5);
        check("csr_imm", out_imm, 32'd5);
        check("csr_ill", out_illegal, 1'b0);
`else
        check("csr_ill", out_illegal, 1'b1);
        check("csr_sel", out_imm_sel, 3'd0);
`endif
        step(0, 32'h0, 32'h0, 1, 0);

        // randomized traffic with a reset in the middle
        pc = 32'h1000;
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            r = $urandom();
            inst = {r[31:7], opc_tbl[$urandom_range(0, 11)]};
            if ($urandom_range(0, 9) == 0) inst = $urandom();
            step($urandom_range(0, 3) != 0, inst, pc, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0);
            pc += 4;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_ctrl.md
Name: decode_ctrl

Overview:
- Decode-stage controller between instruction fetch and execute in the RISC-V core.
- Accepts fetched instruction/PC pairs over a valid/ready handshake.
- Classifies the opcode into an immediate format select and flags unsupported opcodes.
- Drives the immediate generator and presents a registered decode bundle to execute through a 2-entry skid buffer, with flush support on redirects.

Parameters:
- XLEN, 32, width of instruction, PC and immediate.
- RESET_PC, 32'h0000_0000, PC value held in output registers after reset.

Ports:
- clk  input  1  core clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard all buffered entries (branch/jump redirect).
- in_valid  input  1  fetch offers an instruction.
- in_ready  output  1  decode can accept this cycle.
- in_inst  input  XLEN  fetched instruction word.
- in_pc  input  XLEN  PC of in_inst.
- out_valid  output  1  decode bundle valid.
- out_ready  input  1  execute accepts the bundle.
- out_inst  output  XLEN  instruction word.
- out_pc  output  XLEN  PC.
- out_imm  output  XLEN  generated immediate.
- out_imm_sel  output  3  immediate format code.
- out_illegal  output  1  opcode not supported.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: out_valid=0, out_inst=32'h0000_0013 (NOP), out_pc=RESET_PC, out_imm=0, out_imm_sel=0, out_illegal=0, both buffer entries invalid. in_ready=0 while rst is high and 1 on the first cycle after rst drops.
- Transfers: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Latency: 1 cycle from input transfer to out_valid, when the main entry is empty or draining in the same cycle.
- Handshake stability: while out_valid=1 and out_ready=0, all out_* fields are held stable.
- State machine (main and skid entries):
  - EMPTY: in_ready=1, out_valid=0. Input transfer goes to BUSY (loads main).
  - BUSY: in_ready=1, out_valid=1.
    - Input and output transfer together: main reloads, stay BUSY.
    - Output transfer only: go to EMPTY.
    - Input transfer only: load skid, go to FULL.
  - FULL: in_ready=0, out_valid=1. Output transfer moves skid to main, go to BUSY.
- in_ready is a pure function of state, with no combinational path from out_ready.
- Decode, computed from in_inst on entry and stored with the entry:
  - imm_sel=0 (I-type): opcodes 0010011, 0000011, 1100111.
  - imm_sel=1 (S-type): opcode 0100011.
  - imm_sel=2 (B-type): opcode 1100011.
  - imm_sel=3 (U-type): opcodes 0110111, 0010111.
  - imm_sel=4 (J-type): opcode 1101111.
  - imm_sel=5 (CSR immediate): opcode 1110011 with funct3[2]=1 (see Optional Feature).
  - opcode 0110011 (R-type): imm_sel=0, illegal=0.
  - Any other opcode: imm_sel=0, illegal=1. The entry still passes through; it is not dropped.
- Immediate format rules:
  - I-type and S-type: 12 bits, sign-extended.
  - B-type and J-type: sign-extended, LSB forced to 0.
  - U-type: inst[31:12] followed by 12 zero bits.
  - CSR immediate: 5 bits, zero-extended.
- Flush:
  - Next state is EMPTY and both entries are invalidated, regardless of other inputs.
  - An in_valid presented in the flush cycle is dropped, even though in_ready may be 1.
  - An out_ready in the flush cycle still completes that output transfer.
- Priority: rst over flush over normal operation.
- Reset mid-operation: all buffered instructions are discarded, same as the reset values.

Optional Feature:
- Macro: DECODE_CSR_EN.
- Defined: opcode 1110011 decodes as legal.
  - funct3[2]=1 gives imm_sel=5 (zimm).
  - funct3[2]=0 gives imm_sel=0.
- Not defined: opcode 1110011 gives illegal=1 and imm_sel=0, and no CSR decode logic is synthesized.

Decomposition:
- Shared constants package/header:
  - opcode constants (OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM, OPC_OP);
  - IMM_SEL codes 0–5;
  - NOP encoding.
- Sub-module: the existing imm_gen, instantiated once on the input side so the immediate is captured with the entry.
- Entry storage and state machine are inline.

Test Plan:
- Reset, then in_inst=32'h0050_0093 (addi x1,x0,5), pc=0x100, out_ready=1 -> next cycle: out_valid=1, out_imm=5, out_imm_sel=0, out_illegal=0.
- Back-pressure: out_ready=0, send 0xFE00_0EE3 (beq) then 0x0000_006F (jal) -> in_ready=0 after the second transfer. out_ready=1 -> beq (imm=0xFFFF_FFFC, sel=2) then jal (imm=0, sel=4), in order, neither lost.
- Full streaming: in_valid=out_ready=1 with 8 consecutive PCs -> one output per cycle, in order, state never reaches FULL.
- Flush while FULL, with in_valid=1 in the flush cycle -> next cycle out_valid=0, in_ready=1, and the offered instruction never appears.
- 0x1234_5037 (lui) -> imm=0x1234_5000, sel=3. Opcode 0000000 -> illegal=1.
- 0x0002_D073 (csrrwi): with DECODE_CSR_EN -> sel=5, imm=5, illegal=0. Without it -> illegal=1.
